pipe_stage_skid: RTL

Parametrised pipeline stage register, successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque datapath payload and a control field, and adds a valid/ready handshake. A 2-entry skid buffer lets a downstream stall back-propagate without a combinational ready path. It also supports flush-to-bubble, debug single-step gating and a bubble counter for the debug unit.

---
 rtl/pipe_stage_skid.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. A downstream stall reaches o_ready one edge late, so there is no
// combinational path from i_ready to o_ready. The stage also supports
// flush-to-bubble, debug single-step gating and a saturating bubble counter.
// All state changes on the falling edge of i_clk.
//
// Ports:
//   i_clk          clock (falling-edge active)
//   i_reset        synchronous active-high reset, works even when i_step=0
//   i_step         advance enable; no state change on an edge where it is 0
//   i_valid        upstream has an instruction
//   o_ready        stage can accept (registered state only)
//   i_data/i_ctrl  upstream payload and control field
//   i_flush        discard held and incoming instructions
//   o_valid        main entry holds an instruction
//   i_ready        downstream accepts
//   o_data/o_ctrl  main entry payload / control (control masked by o_valid)
//   o_occupancy    number of entries held, 0..2
//   o_bubble_count saturating count of stepped edges with o_valid=0, i_ready=1
module pipe_stage_skid #(
  parameter int NB_DATA  = 32,
  parameter int NB_CTRL  = 8,
  parameter int NB_COUNT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_step,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_CTRL-1:0]  i_ctrl,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_DATA-1:0]  o_data,
  output logic [NB_CTRL-1:0]  o_ctrl,
  output logic [1:0]          o_occupancy,
  output logic [NB_COUNT-1:0] o_bubble_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

  state_t              state;
  state_t              state_next;
  logic [NB_DATA-1:0]  main_data;
  logic [NB_CTRL-1:0]  main_ctrl;
  logic [NB_DATA-1:0]  skid_data;
  logic [NB_CTRL-1:0]  skid_ctrl;
  logic [NB_COUNT-1:0] bubble_count;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic clear_all;

  assign o_ready = (state != FULL);
  assign o_valid = (state != EMPTY);
  assign accept  = i_valid & o_ready;
  assign consume = o_valid & i_ready;

  assign o_data         = main_data;
  assign o_ctrl         = main_ctrl & {NB_CTRL{o_valid}};
  assign o_bubble_count = bubble_count;

  always_comb begin
    o_occupancy = 2'd0;
    case (state)
      EMPTY:   o_occupancy = 2'd0;
      ONE:     o_occupancy = 2'd1;
      FULL:    o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_all      = 1'b0;
    // Flush wins over any accept/consume on the same edge; an instruction
    // consumed on that edge has already been seen downstream.
    if (i_flush) begin
      clear_all  = 1'b1;
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Downstream stalled while upstream still sent: park in skid.
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            load_main_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: begin
          clear_all  = 1'b1;
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state <= EMPTY;
    end else if (i_step) begin
      state <= state_next;
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (i_step) begin
      if (clear_all) begin
        main_data <= '0;
        main_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main_in) begin
          main_data <= i_data;
          main_ctrl <= i_ctrl;
        end else if (load_main_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end
        if (load_skid) begin
          skid_data <= i_data;
          skid_ctrl <= i_ctrl;
        end
      end
    end
  end

  // Bubble condition is sampled on the pre-edge state; flush does not clear it.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      bubble_count <= '0;
    end else if (i_step && !o_valid && i_ready && (bubble_count != COUNT_MAX)) begin
      bubble_count <= bubble_count + NB_COUNT'(1);
    end
  end

endmodule
